// File: rtl/dmem_responder_if.sv
// Request/response bus between the pipeline MEM stage (master) and dmem_responder (slave).
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Wait-stated 16-bit data memory responder: IDLE -> (WAIT) -> RESP handshake FSM.
// Define DMEM_WAIT_EN to enable the WAIT state and WAIT_CYCLES counter; otherwise latency is 1.
module dmem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    dmem_responder_if.slave bus
);
    localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("dmem_responder: WAIT_CYCLES must be in 0..15");
    end

`ifdef DMEM_WAIT_EN
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_e;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd2} state_e;
`endif

    state_e        state_q, state_d;
    logic          commit;
    logic          acc_write;
    logic          acc_err;
    logic [15:0]   acc_addr;
    logic [15:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic [15:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [15:0]   mem [DEPTH];

`ifdef DMEM_WAIT_EN
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [15:0] wdata_q;

    // With zero wait states the access commits on the accept edge, so take the live inputs.
    assign acc_write = (state_q == IDLE) ? bus.req_write : wr_q;
    assign acc_addr  = (state_q == IDLE) ? bus.req_addr  : addr_q;
    assign acc_wdata = (state_q == IDLE) ? bus.req_wdata : wdata_q;
`else
    assign acc_write = bus.req_write;
    assign acc_addr  = bus.req_addr;
    assign acc_wdata = bus.req_wdata;
`endif

    assign acc_idx = acc_addr[AW:1];
    assign acc_err = acc_addr[0] | ({2'b00, acc_addr[15:1]} >= DEPTH_W);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        state_d       = state_q;
        commit        = 1'b0;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
`ifdef DMEM_WAIT_EN
        cnt_d         = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                bus.req_ready = reset_n;
                if (bus.req_valid) begin
`ifdef DMEM_WAIT_EN
                    if (WAIT_LD == 4'd0) begin
                        state_d = RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_LD;
                    end
`else
                    state_d = RESP;
                    commit  = 1'b1;
`endif
                end
            end
`ifdef DMEM_WAIT_EN
            WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (commit) begin
            err_d   = acc_err;
            rdata_d = (acc_err || acc_write) ? 16'h0000 : mem[acc_idx];
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: registers use <= so every flop samples the pre-edge values.
        if (!reset_n) begin
            state_q <= IDLE;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
`ifdef DMEM_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef DMEM_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

`ifdef DMEM_WAIT_EN
    always_ff @(posedge clock) begin
        if (state_q == IDLE && bus.req_valid) begin
            wr_q    <= bus.req_write;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
        end
    end
`endif

    // NOTE: the array has no reset; contents must survive reset, and a reset in WAIT blocks the write.
    always_ff @(posedge clock) begin
        if (reset_n && commit && acc_write && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed steps plus random traffic against a word-map model.
module tb_dmem_responder;
    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
`ifdef DMEM_WAIT_EN
    localparam int EXP_LAT = WAIT_CYCLES + 1;
`else
    localparam int EXP_LAT = 1;
`endif

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   n_cmp   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_acc = 0;

    // Reference model: word index -> last successfully stored value.
    logic [15:0] mdl [int];

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic addr_bad(input logic [15:0] a);
        return a[0] || (int'(a[15:1]) >= DEPTH);
    endfunction

    task automatic do_reset(input int n);
        reset_n       = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        repeat (n) @(posedge clock);
        @(negedge clock);
        check("rst/req_ready", bus.req_ready, 0);
        check("rst/rsp_valid", bus.rsp_valid, 0);
        check("rst/rsp_rdata", bus.rsp_rdata, 0);
        check("rst/rsp_err",   bus.rsp_err,   0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        check("rst/ready_after", bus.req_ready, 1);
    endtask

    // One full transaction; called away from a clock edge, returns #1 after the handshake edge.
    task automatic xact(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                        input int hold, input string tag);
        logic        e_err;
        logic [15:0] e_rd;
        int          lat;
        bit          ok;
        e_err = addr_bad(addr);
        e_rd  = 16'h0000;
        if (!e_err && !wr) e_rd = mdl[int'(addr[15:1])];
        if (!e_err && wr)  mdl[int'(addr[15:1])] = wd;

        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.rsp_ready = 1'b0;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready === 1'b1) begin
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        check({tag, "/accept"}, ok, 1);
        if (!ok) return;
        @(posedge clock);
        #1;
        last_acc = cyc;
        // Keep presenting junk so later input changes must be ignored.
        bus.req_write = 1'($urandom);
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = 16'($urandom);

        lat = 1;
        ok  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (bus.rsp_valid === 1'b1) begin
                ok = 1;
                break;
            end
            check({tag, "/ready_in_wait"}, bus.req_ready, 0);
            @(posedge clock);
            lat++;
        end
        check({tag, "/rsp_seen"}, ok, 1);
        if (!ok) return;
        check({tag, "/latency"}, lat, EXP_LAT);
        check({tag, "/rdata"}, bus.rsp_rdata, e_rd);
        check({tag, "/err"}, bus.rsp_err, e_err);
        check({tag, "/ready_in_resp"}, bus.req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            check({tag, "/hold_valid"}, bus.rsp_valid, 1);
            check({tag, "/hold_rdata"}, bus.rsp_rdata, e_rd);
            check({tag, "/hold_err"}, bus.rsp_err, e_err);
            check({tag, "/hold_ready"}, bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b0;
        check({tag, "/valid_after_hs"}, bus.rsp_valid, 0);
        check({tag, "/ready_after_hs"}, bus.req_ready, 1);
    endtask

    initial begin
        int          prev;
        logic        wr;
        logic [15:0] addr;
        int          w;
        int          sel;

        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 16'h0000;
        bus.req_wdata = 16'h0000;
        bus.rsp_ready = 1'b0;

        do_reset(3);

        // Basic store/store/load.
        xact(1'b1, 16'h0000, 16'h0005, 0, "st0");
        xact(1'b1, 16'h0002, 16'h0007, 0, "st2");
        xact(1'b0, 16'h0002, 16'h0000, 0, "ld2");

        // Load right after store to same word, with a held response.
        xact(1'b1, 16'h0010, 16'h1234, 0, "st10");
        xact(1'b0, 16'h0010, 16'h0000, 5, "ld10_hold");

        // Error cases and the last legal word.
        xact(1'b1, 16'h0100, 16'hA5A5, 0, "st100");
        xact(1'b1, 16'h01FE, 16'h5A5A, 1, "st_last");
        xact(1'b0, 16'h0003, 16'h0000, 0, "ld_misal");
        xact(1'b0, 16'h0200, 16'h0000, 2, "ld_range");
        xact(1'b1, 16'h0101, 16'hFFFF, 0, "st_misal");
        xact(1'b1, 16'h0200, 16'hFFFF, 0, "st_range");
        xact(1'b0, 16'h0100, 16'h0000, 0, "ld100");
        xact(1'b0, 16'h01FE, 16'h0000, 0, "ld_last");
        xact(1'b0, 16'h0000, 16'h0000, 0, "ld0");

        // Reset with a store in flight.
        xact(1'b1, 16'h0020, 16'h0A0A, 0, "st20");
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 16'h0020;
        bus.req_wdata = 16'hBEEF;
        check("rstmid/ready", bus.req_ready, 1);
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
`ifdef DMEM_WAIT_EN
        check("rstmid/in_wait", bus.rsp_valid, 0);
`else
        check("rstmid/in_resp", bus.rsp_valid, 1);
        mdl[16] = 16'hBEEF;
`endif
        do_reset(2);
        xact(1'b0, 16'h0020, 16'h0000, 0, "ld20_after_rst");

        // Back-to-back loads: accepts spaced by latency plus the handshake bubble.
        for (int i = 0; i < 4; i++) begin
            prev = last_acc;
            xact(1'b0, (i % 2 == 0) ? 16'h0002 : 16'h0010, 16'h0000, 0, "b2b");
            if (i > 0) check("b2b/spacing", last_acc - prev, EXP_LAT + 1);
        end

        // Random traffic against the model.
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 9));
            wr  = 1'($urandom);
            if (sel == 0) begin
                addr = 16'($urandom) | 16'h0001;
            end else if (sel == 1) begin
                addr = 16'(($urandom_range(256, 32767)) * 2);
            end else begin
                addr = 16'(($urandom_range(0, 15)) * 2);
            end
            w = int'(addr[15:1]);
            if (!addr_bad(addr) && !wr && !mdl.exists(w)) wr = 1'b1;
            xact(wr, addr, 16'($urandom), int'($urandom_range(0, 3)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
